alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries; SHALL be a power of two, >= 2.
REQ-002 iCLK  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 iRST  in  1  synchronous, active-high reset, sampled on iCLK rising edge only.
REQ-004 iVALID  in  1  upstream command valid.
REQ-005 oREADY  out  1  command accepted on an edge where iVALID && oREADY.
REQ-006 iA, iB, iINST  in  4 each  command operands and opcode.
REQ-007 oALU_A, oALU_B, oALU_INST  out  4 each  registered operands and opcode driven to the downstream ALU.
REQ-008 iALU_RESULT  in  8  ALU combinational result.
REQ-009 oVALID  out  1  result valid; iREADY  in  1  downstream ready.
REQ-010 oRESULT  out  8  captured result; oINST  out  4  opcode of that result; oERR  out  1  divide/modulo-by-zero flag.
REQ-011 oCOUNT  out  log2(DEPTH)+1  FIFO occupancy.

Function
REQ-012 FIFO SHALL store {iA,iB,iINST} on each accepting edge; oREADY SHALL be 1 iff occupancy < DEPTH and iRST is 0.
REQ-013 iVALID while oREADY=0 SHALL be ignored; no entry written, no state change.
REQ-014 Push and pop on the same edge SHALL both occur; occupancy unchanged; a push on a full-FIFO edge is refused even if a pop occurs that edge.
REQ-015 Read/write pointers SHALL wrap from DEPTH-1 to 0; order SHALL be strict FIFO.
REQ-016 FSM states: IDLE, EXEC, HOLD.
REQ-017 IDLE: FIFO non-empty -> pop head into oALU_A/B/INST, go EXEC; else stay.
REQ-018 EXEC (exactly one cycle): capture iALU_RESULT into oRESULT, oALU_INST into oINST, set oVALID=1, go HOLD.
REQ-019 HOLD: oVALID, oRESULT, oINST, oERR SHALL stay stable until iVALID-independent handshake oVALID && iREADY.
REQ-020 HOLD on handshake: FIFO non-empty -> pop next, clear oVALID, go EXEC; empty -> clear oVALID, go IDLE.
REQ-021 Latency: command accepted at edge E with FSM idle and FIFO empty -> oVALID high after edge E+2; back-to-back throughput one result per 2 cycles with iREADY held 1.
REQ-022 In EXEC, if oALU_INST is 4'h3 or 4'h4 and oALU_B == 0, oRESULT SHALL be 8'hFF and oERR=1; otherwise oERR=0 and oRESULT = iALU_RESULT.
REQ-023 oALU_A/B/INST SHALL hold last popped values in IDLE and HOLD.
REQ-024 oCOUNT SHALL equal entries written minus entries popped, range 0..DEPTH.

Reset
REQ-025 On iRST=1 at an edge: FIFO emptied, pointers 0, state IDLE, oVALID=0, oRESULT=8'h00, oINST=4'h0, oERR=0, oALU_A/B/INST=4'h0, oCOUNT=0.
REQ-026 iRST mid-operation SHALL discard queued commands and any pending result with no handshake; iVALID on the reset edge SHALL not be accepted.
REQ-027 First edge after iRST deasserts SHALL behave as IDLE with empty FIFO.

Structure
REQ-028 Shared package alu_pkg SHALL hold opcode constants OP_ADD=4'h0 ... OP_LSHFT=4'hf, FSM state enum, and DEPTH default.
REQ-029 Storage SHALL be one sub-module alu_cmd_fifo (push/pop/full/empty/count, width 12); FSM and result capture in alu_issue; ALU itself external.

Verification
REQ-030 Reset, then push {A=3,B=5,INST=0}, ALU model attached, iREADY=1 -> oVALID after 2 edges, oRESULT=8'h08, oINST=0, oERR=0.
REQ-031 Push 4 commands with iREADY=0 -> oCOUNT 4 then 3 after first pop, oREADY 0 at count 4, 5th iVALID ignored; release iREADY -> results in push order.
REQ-032 Push {A=9,B=0,INST=3} and {A=9,B=0,INST=4} -> oRESULT=8'hFF, oERR=1 each; next {A=9,B=2,INST=3} -> 8'h04, oERR=0.
REQ-033 Full FIFO, iVALID=1 and handshake on same edge -> no push, oCOUNT 4->3; next edge push accepted.
REQ-034 Assert iRST while in HOLD with 2 queued -> next cycle oVALID=0, oCOUNT=0, oREADY=1; no stale result emerges.
REQ-035 Run >2*DEPTH commands continuously with iREADY=1 -> pointer wrap, no loss/duplication, one result per 2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue slice: opcodes, FSM states and the
// default command-queue depth.
package alu_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam int CMD_WIDTH     = 12;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_MOD   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_NAND  = 4'h9;
    localparam logic [3:0] OP_NOR   = 4'ha;
    localparam logic [3:0] OP_XNOR  = 4'hb;
    localparam logic [3:0] OP_INC   = 4'hc;
    localparam logic [3:0] OP_DEC   = 4'hd;
    localparam logic [3:0] OP_RSHFT = 4'he;
    localparam logic [3:0] OP_LSHFT = 4'hf;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Divide and modulo by zero are trapped here instead of trusting the ALU.
    function automatic logic isDivZero(input logic [3:0] inst, input logic [3:0] b);
        return ((inst == OP_DIV) || (inst == OP_MOD)) && (b == 4'h0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue holding packed {A,B,INST} words ahead of the issue FSM.
// Push on full and pop on empty are silently refused.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iPUSH,
    input  logic                     iPOP,
    input  logic [WIDTH-1:0]         iDATA,
    output logic [WIDTH-1:0]         oDATA,
    output logic                     oFULL,
    output logic                     oEMPTY,
    output logic [$clog2(DEPTH):0]   oCOUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign oFULL  = (r_count == FULL_COUNT);
    assign oEMPTY = (r_count == '0);
    assign oCOUNT = r_count;
    assign oDATA  = r_mem[r_rdPtr];
    assign w_push = iPUSH && !oFULL && !iRST;
    assign w_pop  = iPOP && !oEMPTY && !iRST;

    // Storage array needs no reset: the pointers decide what is valid.
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= iDATA;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: queues commands, drives them to an external ALU one at a time
// and holds each captured result until the downstream side takes it.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iVALID,
    output logic                     oREADY,
    input  logic [3:0]               iA,
    input  logic [3:0]               iB,
    input  logic [3:0]               iINST,
    output logic [3:0]               oALU_A,
    output logic [3:0]               oALU_B,
    output logic [3:0]               oALU_INST,
    input  logic [7:0]               iALU_RESULT,
    output logic                     oVALID,
    input  logic                     iREADY,
    output logic [7:0]               oRESULT,
    output logic [3:0]               oINST,
    output logic                     oERR,
    output logic [$clog2(DEPTH):0]   oCOUNT
);

    state_t               r_state;
    logic [3:0]           r_aluA;
    logic [3:0]           r_aluB;
    logic [3:0]           r_aluInst;
    logic                 r_valid;
    logic [7:0]           r_result;
    logic [3:0]           r_inst;
    logic                 r_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [CMD_WIDTH-1:0] w_head;

    assign oREADY = !w_full && !iRST;
    assign w_push = iVALID && oREADY;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_WIDTH)
    ) u_fifo (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iPUSH  (w_push),
        .iPOP   (w_pop),
        .iDATA  ({iA, iB, iINST}),
        .oDATA  (w_head),
        .oFULL  (w_full),
        .oEMPTY (w_empty),
        .oCOUNT (oCOUNT)
    );

    // Pop only where the FSM is about to load a new command into the ALU regs.
    always_comb begin
        w_pop = 1'b0;
        if (!iRST) begin
            case (r_state)
                ST_IDLE: w_pop = !w_empty;
                ST_HOLD: w_pop = iREADY && !w_empty;
                default: w_pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state   <= ST_IDLE;
            r_aluA    <= 4'h0;
            r_aluB    <= 4'h0;
            r_aluInst <= 4'h0;
            r_valid   <= 1'b0;
            r_result  <= 8'h00;
            r_inst    <= 4'h0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_aluA, r_aluB, r_aluInst} <= w_head;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (isDivZero(r_aluInst, r_aluB)) begin
                        r_result <= 8'hFF;
                        r_err    <= 1'b1;
                    end else begin
                        r_result <= iALU_RESULT;
                        r_err    <= 1'b0;
                    end
                    r_inst  <= r_aluInst;
                    r_valid <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (iREADY) begin
                        r_valid <= 1'b0;
                        if (w_pop) begin
                            {r_aluA, r_aluB, r_aluInst} <= w_head;
                            r_state <= ST_EXEC;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oALU_A    = r_aluA;
    assign oALU_B    = r_aluB;
    assign oALU_INST = r_aluInst;
    assign oVALID    = r_valid;
    assign oRESULT   = r_result;
    assign oINST     = r_inst;
    assign oERR      = r_err;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a small behavioural ALU attached.
module tb_alu_issue;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iVALID;
    logic       oREADY;
    logic [3:0] iA, iB, iINST;
    logic [3:0] oALU_A, oALU_B, oALU_INST;
    logic [7:0] iALU_RESULT;
    logic       oVALID;
    logic       iREADY;
    logic [7:0] oRESULT;
    logic [3:0] oINST;
    logic       oERR;
    logic [$clog2(DEPTH):0] oCOUNT;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] inst;
        logic [7:0] expResult;
        logic       expErr;
    } vec_t;

    vec_t vecs [12];

    alu_issue #(.DEPTH(DEPTH)) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iVALID      (iVALID),
        .oREADY      (oREADY),
        .iA          (iA),
        .iB          (iB),
        .iINST       (iINST),
        .oALU_A      (oALU_A),
        .oALU_B      (oALU_B),
        .oALU_INST   (oALU_INST),
        .iALU_RESULT (iALU_RESULT),
        .oVALID      (oVALID),
        .iREADY      (iREADY),
        .oRESULT     (oRESULT),
        .oINST       (oINST),
        .oERR        (oERR),
        .oCOUNT      (oCOUNT)
    );

    always #5 iCLK = ~iCLK;

    // Divide/modulo by zero deliberately returns 0 so the trap must come from the DUT.
    function automatic logic [7:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] inst);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (inst)
            OP_ADD:   return ea + eb;
            OP_SUB:   return ea - eb;
            OP_MUL:   return ea * eb;
            OP_DIV:   return (b == 4'h0) ? 8'h00 : ea / eb;
            OP_MOD:   return (b == 4'h0) ? 8'h00 : ea % eb;
            OP_AND:   return ea & eb;
            OP_OR:    return ea | eb;
            OP_XOR:   return ea ^ eb;
            OP_LSHFT: return ea << b;
            default:  return 8'h00;
        endcase
    endfunction

    assign iALU_RESULT = aluModel(oALU_A, oALU_B, oALU_INST);

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] inst);
        iVALID = 1'b1;
        iA     = a;
        iB     = b;
        iINST  = inst;
    endtask

    task automatic drainOne(input logic [7:0] expected, input string name);
        int n;
        n = 0;
        while (!oVALID && n < 10) begin
            tick();
            n++;
        end
        checkOutput({name, "_valid"}, int'(oVALID), 1);
        checkOutput({name, "_result"}, int'(oRESULT), int'(expected));
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int txIdx, rxIdx, cycle, lastCycle;
        logic accept;

        vecs[0]  = '{4'h3, 4'h5, OP_ADD,   8'h08, 1'b0};
        vecs[1]  = '{4'h9, 4'h0, OP_DIV,   8'hFF, 1'b1};
        vecs[2]  = '{4'h9, 4'h0, OP_MOD,   8'hFF, 1'b1};
        vecs[3]  = '{4'h9, 4'h2, OP_DIV,   8'h04, 1'b0};
        vecs[4]  = '{4'h9, 4'h2, OP_MOD,   8'h01, 1'b0};
        vecs[5]  = '{4'h7, 4'h3, OP_SUB,   8'h04, 1'b0};
        vecs[6]  = '{4'hF, 4'hF, OP_MUL,   8'hE1, 1'b0};
        vecs[7]  = '{4'hA, 4'h6, OP_AND,   8'h02, 1'b0};
        vecs[8]  = '{4'hA, 4'h5, OP_OR,    8'h0F, 1'b0};
        vecs[9]  = '{4'h0, 4'h0, OP_ADD,   8'h00, 1'b0};
        vecs[10] = '{4'h5, 4'h0, OP_XOR,   8'h05, 1'b0};
        vecs[11] = '{4'h1, 4'h3, OP_LSHFT, 8'h08, 1'b0};

        iRST   = 1'b1;
        iREADY = 1'b1;
        applyStimulus(4'h6, 4'h6, OP_ADD);
        tick();
        tick();
        checkOutput("rst_ready_low", int'(oREADY), 0);
        checkOutput("rst_valid",     int'(oVALID), 0);
        checkOutput("rst_count",     int'(oCOUNT), 0);
        checkOutput("rst_result",    int'(oRESULT), 0);
        checkOutput("rst_inst",      int'(oINST), 0);
        checkOutput("rst_err",       int'(oERR), 0);
        checkOutput("rst_alu_a",     int'(oALU_A), 0);
        checkOutput("rst_alu_b",     int'(oALU_B), 0);
        checkOutput("rst_alu_inst",  int'(oALU_INST), 0);
        iRST   = 1'b0;
        iVALID = 1'b0;
        #1;
        checkOutput("post_rst_ready", int'(oREADY), 1);

        // Single commands from an idle, empty queue: latency and result capture.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].inst);
            tick();
            iVALID = 1'b0;
            checkOutput($sformatf("vec%0d_count_e", i), int'(oCOUNT), 1);
            tick();
            checkOutput($sformatf("vec%0d_valid_e1", i), int'(oVALID), 0);
            tick();
            checkOutput($sformatf("vec%0d_valid_e2", i), int'(oVALID), 1);
            checkOutput($sformatf("vec%0d_result", i), int'(oRESULT), int'(vecs[i].expResult));
            checkOutput($sformatf("vec%0d_inst", i), int'(oINST), int'(vecs[i].inst));
            checkOutput($sformatf("vec%0d_err", i), int'(oERR), int'(vecs[i].expErr));
            tick();
            checkOutput($sformatf("vec%0d_valid_after", i), int'(oVALID), 0);
            checkOutput($sformatf("vec%0d_alu_a_hold", i), int'(oALU_A), int'(vecs[i].a));
        end

        // Backpressure: fill the queue, extra command refused, drain in order.
        iREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'(k + 1), 4'h1, OP_ADD);
            checkOutput($sformatf("bp_ready_%0d", k), int'(oREADY), 1);
            tick();
        end
        checkOutput("bp_count_full", int'(oCOUNT), 4);
        checkOutput("bp_ready_full", int'(oREADY), 0);
        applyStimulus(4'hF, 4'hF, OP_ADD);
        tick();
        tick();
        checkOutput("bp_count_ignored", int'(oCOUNT), 4);
        checkOutput("bp_hold_valid", int'(oVALID), 1);
        checkOutput("bp_hold_result", int'(oRESULT), 8'h02);
        iVALID = 1'b0;
        iREADY = 1'b1;
        drainOne(8'h02, "bp_r0");
        checkOutput("bp_count_after_pop", int'(oCOUNT), 3);
        for (int k = 1; k < 5; k++) begin
            drainOne(8'(k + 2), $sformatf("bp_r%0d", k));
        end
        checkOutput("bp_count_empty", int'(oCOUNT), 0);
        checkOutput("bp_valid_idle", int'(oVALID), 0);

        // Full queue with push attempt and handshake on the same edge.
        iREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'(k), 4'(k), OP_ADD);
            tick();
        end
        checkOutput("fh_count_full", int'(oCOUNT), 4);
        applyStimulus(4'h7, 4'h7, OP_ADD);
        iREADY = 1'b1;
        tick();
        checkOutput("fh_count_refused", int'(oCOUNT), 3);
        checkOutput("fh_ready_again", int'(oREADY), 1);
        tick();
        checkOutput("fh_count_pushed", int'(oCOUNT), 4);
        iVALID = 1'b0;
        drainOne(8'h02, "fh_r1");
        drainOne(8'h04, "fh_r2");
        drainOne(8'h06, "fh_r3");
        drainOne(8'h08, "fh_r4");
        drainOne(8'h0E, "fh_rx");
        checkOutput("fh_count_empty", int'(oCOUNT), 0);

        // Reset while holding a result with two commands queued.
        iREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'h2, 4'(k), OP_ADD);
            tick();
        end
        checkOutput("mr_valid_pre", int'(oVALID), 1);
        checkOutput("mr_count_pre", int'(oCOUNT), 2);
        iRST = 1'b1;
        applyStimulus(4'h4, 4'h4, OP_ADD);
        tick();
        checkOutput("mr_valid", int'(oVALID), 0);
        checkOutput("mr_count", int'(oCOUNT), 0);
        checkOutput("mr_result", int'(oRESULT), 0);
        checkOutput("mr_alu_a", int'(oALU_A), 0);
        iRST   = 1'b0;
        iVALID = 1'b0;
        iREADY = 1'b1;
        #1;
        checkOutput("mr_ready", int'(oREADY), 1);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("mr_no_stale_%0d", k), int'(oVALID), 0);
        end
        checkOutput("mr_count_after", int'(oCOUNT), 0);

        // Continuous stream longer than twice the depth to exercise pointer wrap.
        iREADY    = 1'b1;
        txIdx     = 0;
        rxIdx     = 0;
        cycle     = 0;
        lastCycle = -1;
        while (rxIdx < 12 && cycle < 200) begin
            if (oVALID) begin
                checkOutput($sformatf("wrap_r%0d", rxIdx), int'(oRESULT), rxIdx + 3);
                if (lastCycle >= 0) begin
                    checkOutput($sformatf("wrap_gap%0d", rxIdx), cycle - lastCycle, 2);
                end
                lastCycle = cycle;
                rxIdx++;
            end
            if (txIdx < 12) begin
                applyStimulus(txIdx[3:0], 4'h3, OP_ADD);
            end else begin
                iVALID = 1'b0;
            end
            accept = iVALID && oREADY;
            tick();
            cycle++;
            if (accept) begin
                txIdx++;
            end
        end
        iVALID = 1'b0;
        checkOutput("wrap_rx_total", rxIdx, 12);
        checkOutput("wrap_tx_total", txIdx, 12);
        tick();
        checkOutput("wrap_valid_end", int'(oVALID), 0);
        checkOutput("wrap_count_end", int'(oCOUNT), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
